alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU (add/sub/and/or).
- Generalises width, widens the opcode to 3 bits and adds status flags.
- Adds a valid/ready handshake on both sides and an iterative multi-cycle multiply.
- Sits between the operand-fetch stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>=4).
- SHW, $clog2(WIDTH), number of b LSBs used as the shift amount (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand/op present.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation select (alu_op_e).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flag_z  out  1  zero flag.
- flag_n  out  1  negative flag.
- flag_c  out  1  carry flag.
- flag_v  out  1  overflow flag.

Interface rule (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Opcodes 000–011 keep the predecessor's encodings, zero-extended:
  - 000 ADD, 001 SUB (a-b), 010 AND, 011 OR.
  - 100 XOR.
  - 101 SLT: signed a<b gives result 1, else 0.
  - 110 SHL: a << b[SHW-1:0].
  - 111 MUL: unsigned, low WIDTH bits kept.
- All arithmetic wraps modulo 2^WIDTH.
- Flags:
  - Z = (result==0). N = result[WIDTH-1].
  - ADD: C = carry-out, V = signed overflow.
  - SUB: C = NOT borrow (a>=b unsigned), V = signed overflow.
  - MUL: C = 0, V = 1 if the upper WIDTH bits of the full product are nonzero.
  - All other ops: C = V = 0.
- Handshake:
  - An operation is accepted on the edge where in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst.
  - out_valid, result and flags hold stable until the edge with out_valid && out_ready.
  - Simultaneous pop and accept in the same cycle is legal (full throughput for single-cycle ops).
- FSM states: IDLE, MUL.
  - IDLE plus accept of a non-MUL op: result and flags are registered, and out_valid=1 after that edge (latency 1).
  - IDLE plus accept of MUL: load multiplicand, multiplier, accumulator and count=0, then go to MUL. in_ready=0 while in MUL.
  - MUL: one shift-add step per edge. After the WIDTH-th edge in MUL, result and flags are registered, out_valid=1 and state returns to IDLE (latency WIDTH+1 from the accept edge).
  - MUL entry is allowed only when out_valid is clear or being popped (this is already guaranteed by in_ready).
- Reset values: state=IDLE, out_valid=0, result=0, all flags=0, internal counter and accumulator = 0.
- Reset asserted mid-MUL aborts the operation; no result is produced.
- Inputs are ignored when in_ready=0. Operands are captured at acceptance, so they may change afterwards.
- Shift amounts >= WIDTH cannot occur (the shift uses only SHW bits).

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL is implemented exactly as above, with the iterative multiplier instantiated.
- Undefined:
  - No MUL state or multiplier logic.
  - op 111 completes in 1 cycle with result=0, Z=1 and N=C=V=0.
  - in_ready never drops for a multiply.

Decomposition:
- Package alu_seq_pkg holds:
  - alu_op_e enum (3-bit, encodings above).
  - alu_flags_t packed struct {z,n,c,v}.
  - alu_state_e enum {IDLE, MUL}.
  - Opcode constants shared with the decoder.
- Sub-module alu_mul_iter: shift-add unsigned multiplier.
  - Ports: start, a, b, done, and a 2*WIDTH product.
  - Instantiated only under ALU_SEQ_MUL_EN.

Test Plan (WIDTH=8):
- ADD a=0x4A, b=0xF4 (74 + -12): result 0x3E (62), C=1, V=0, Z=0, N=0, one cycle after accept.
- SUB 0x4A-0x2C: result 0x1E (30), C=1, V=0. SUB 0x4A-0xCC (74 - -52): result 0x7E (126), C=0, V=0. ADD 0x7F+0x01: result 0x80, V=1, N=1.
- AND 0x4A & 0x27: result 0x02. OR 0x4A | 0x20: result 0x6A. SLT a=0xFF, b=0x01: result 1. SHL 0x81 by b=0x09 (amount 1): result 0x02.
- MUL 13×11: in_ready low for 8 cycles, result 0x8F, N=1, V=0 at cycle 9. MUL 20×20: result 0x90, V=1.
- Back-to-back ADD/SUB with out_ready held low for 3 cycles: result stable, in_ready=0 until the pop, no result lost or duplicated. Then out_ready=1 continuously: one result per cycle.
- rst asserted at cycle 4 of a MUL: out_valid=0, result=0 and flags=0 next cycle, in_ready=1 after rst deasserts. Without ALU_SEQ_MUL_EN, op 111 gives result 0, Z=1 after 1 cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the registered ALU.
//   alu_op_e    - 3-bit opcode; 000..011 match the older combinational ALU
//   alu_flags_t - packed status flags {z, n, c, v}
//   alu_state_e - control FSM states
package alu_seq_pkg;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic {
    IDLE,
    MUL
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add unsigned multiplier, one partial
// product per clock, WIDTH steps per multiply.
//   clk, rst - clock, synchronous active-high reset (aborts a multiply)
//   start    - load a/b and begin; ignored while busy
//   a, b     - WIDTH-bit unsigned operands
//   done     - high during the final step; product is valid that same cycle
//   product  - 2*WIDTH-bit full product (combinational view of the last step)
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic               busy;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // Exposing acc_next lets the caller register the product on the last
  // step edge itself, so no extra cycle is spent after the final add.
  assign product = acc_next;
  assign done    = busy && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      count  <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake on both sides.
// Single-cycle ops: ADD SUB AND OR XOR SLT SHL (latency 1, full throughput).
// MUL is iterative (latency WIDTH+1) when ALU_SEQ_MUL_EN is defined;
// otherwise op 111 completes in one cycle with result 0 and Z=1.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - input handshake; a/b/op captured on acceptance
//   a, b, op            - operands and opcode (alu_op_e)
//   out_valid, out_ready- output handshake; result/flags held until popped
//   result              - registered WIDTH-bit result
//   flag_z/n/c/v        - zero, negative, carry, overflow
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e       state;
  alu_state_e       state_next;
  alu_op_e          op_e;
  logic             accept;
  logic             pop;
  logic             take_single;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flags;
  alu_flags_t       flags_q;

  assign op_e     = alu_op_e'(op);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = a - b;
    alu_res   = '0;
    alu_flags = '0;
    case (op_e)
      OP_ADD: begin
        alu_res     = sum[WIDTH-1:0];
        alu_flags.c = sum[WIDTH];
        alu_flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res     = diff;
        alu_flags.c = (a >= b);
        alu_flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL:  alu_res = a << b[SHW-1:0];
      default: alu_res = '0;
    endcase
    alu_flags.z = (alu_res == '0);
    alu_flags.n = alu_res[WIDTH-1];
  end

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  alu_flags_t         mul_flags;

  assign mul_start   = accept && (op_e == OP_MUL);
  assign take_single = accept && (op_e != OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    mul_flags   = '0;
    mul_flags.z = (mul_prod[WIDTH-1:0] == '0);
    mul_flags.n = mul_prod[WIDTH-1];
    mul_flags.v = |mul_prod[2*WIDTH-1:WIDTH];
  end
`else
  assign take_single = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_start) begin
          state_next = MUL;
        end
`endif
      end
      MUL: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done) begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Pop clears out_valid; a same-edge completion overrides it, giving
  // back-to-back results without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
    end else begin
      if (pop) begin
        out_valid <= 1'b0;
      end
      if (take_single) begin
        result    <= alu_res;
        flags_q   <= alu_flags;
        out_valid <= 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      if ((state == MUL) && mul_done) begin
        result    <= mul_prod[WIDTH-1:0];
        flags_q   <= mul_flags;
        out_valid <= 1'b1;
      end
`endif
    end
  end

  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_c = flags_q.c;
  assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH=8). Flags are
// compared as {z,n,c,v}. Multiply vectors apply when ALU_SEQ_MUL_EN is set.
module tb_alu_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  int unsigned n_total;
  int unsigned n_bad;

  alu_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle op with out_ready high: accepted on the next edge,
  // result visible right after it.
  task automatic run1(input string tag, input logic [2:0] o, input logic [7:0] xa,
                      input logic [7:0] xb, input logic [7:0] exp_res, input logic [3:0] exp_f);
    op = o; a = xa; b = xb; in_valid = 1'b1;
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    a = 8'hxx; b = 8'hxx;
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".res"}, 32'(result), 32'(exp_res));
    check({tag, ".flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(exp_f));
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic run_mul(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                         input logic [7:0] exp_res, input logic [3:0] exp_f);
    op = 3'b111; a = xa; b = xb; in_valid = 1'b1;
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    a = 8'h00; b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".busy_valid"}, 32'(out_valid), 32'd0);
      if (i < 7) step();
    end
    step();
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".res"}, 32'(result), 32'(exp_res));
    check({tag, ".flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(exp_f));
  endtask
`endif

  initial begin
    n_total = 0;
    n_bad = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    step();
    step();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.res", 32'(result), 32'd0);
    check("rst.flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    check("rst.ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst.ready_after", 32'(in_ready), 32'd1);

    //                 op      a      b      res    zncv
    run1("add1",  3'b000, 8'h4A, 8'hF4, 8'h3E, 4'b0010);
    run1("sub1",  3'b001, 8'h4A, 8'h2C, 8'h1E, 4'b0010);
    run1("sub2",  3'b001, 8'h4A, 8'hCC, 8'h7E, 4'b0000);
    run1("add2",  3'b000, 8'h7F, 8'h01, 8'h80, 4'b0101);
    run1("and1",  3'b010, 8'h4A, 8'h27, 8'h02, 4'b0000);
    run1("or1",   3'b011, 8'h4A, 8'h20, 8'h6A, 4'b0000);
    run1("xor1",  3'b100, 8'h4A, 8'h4A, 8'h00, 4'b1000);
    run1("xor2",  3'b100, 8'h0F, 8'hF0, 8'hFF, 4'b0100);
    run1("slt1",  3'b101, 8'hFF, 8'h01, 8'h01, 4'b0000);
    run1("slt2",  3'b101, 8'h01, 8'hFF, 8'h00, 4'b1000);
    run1("shl1",  3'b110, 8'h81, 8'h09, 8'h02, 4'b0000);
    run1("shl2",  3'b110, 8'h01, 8'h07, 8'h80, 4'b0100);
    run1("sub3",  3'b001, 8'h05, 8'h05, 8'h00, 4'b1010);
    run1("sub4",  3'b001, 8'h00, 8'h01, 8'hFF, 4'b0100);
    run1("sub5",  3'b001, 8'h80, 8'h01, 8'h7F, 4'b0011);
    run1("add3",  3'b000, 8'hFF, 8'h01, 8'h00, 4'b1010);
    run1("add4",  3'b000, 8'h80, 8'h80, 8'h00, 4'b1011);

`ifdef ALU_SEQ_MUL_EN
    run_mul("mul1", 8'd13, 8'd11, 8'h8F, 4'b0100);
    run_mul("mul2", 8'd20, 8'd20, 8'h90, 4'b0101);
    run_mul("mul3", 8'hFF, 8'hFF, 8'h01, 4'b0001);
`else
    run1("mul_off", 3'b111, 8'd13, 8'd11, 8'h00, 4'b1000);
`endif
    step();
    check("idle.valid", 32'(out_valid), 32'd0);

    // Backpressure: ADD held while the next op waits.
    out_ready = 1'b0;
    op = 3'b000; a = 8'h01; b = 8'h02; in_valid = 1'b1;
    step();
    op = 3'b001; a = 8'h09; b = 8'h04;
    for (int i = 0; i < 3; i++) begin
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.res", 32'(result), 32'h03);
      check("bp.ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp.ready_pop", 32'(in_ready), 32'd1);
    step();
    check("bp.sub_valid", 32'(out_valid), 32'd1);
    check("bp.sub_res", 32'(result), 32'h05);
    op = 3'b000; a = 8'h10; b = 8'h10;
    step();
    in_valid = 1'b0;
    check("tp.valid", 32'(out_valid), 32'd1);
    check("tp.res", 32'(result), 32'h20);
    step();
    check("tp.nodup", 32'(out_valid), 32'd0);

`ifdef ALU_SEQ_MUL_EN
    // Reset during a multiply aborts it.
    op = 3'b111; a = 8'd20; b = 8'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("mrst.valid", 32'(out_valid), 32'd0);
    check("mrst.res", 32'(result), 32'd0);
    check("mrst.flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    rst = 1'b0;
    #1;
    check("mrst.ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("mrst.no_result", 32'(out_valid), 32'd0);
    end
    run1("mrst.add", 3'b000, 8'h4A, 8'hF4, 8'h3E, 4'b0010);
`endif

    step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
